// File: rtl/gate_gen.sv
// Measurement-gate generator: IDLE -> CLEAR -> GATE -> DEAD sequencer with selectable
// gate length, single-shot or continuous operation, and abort. All outputs registered.
module gate_gen #(
  parameter int CNT_W     = 28,
  parameter int GATE_LEN0 = 50_000_000,
  parameter int GATE_LEN1 = 5_000_000,
  parameter int GATE_LEN2 = 500_000,
  parameter int GATE_LEN3 = 50_000,
  parameter int DEAD_LEN  = 1000
) (
  input  logic             Sys_CLK,
  input  logic             Sys_RST,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic [1:0]       range_sel,
  output logic             gateout,
  output logic             gate_clr,
  output logic             gate_done,
  output logic             busy,
  output logic [1:0]       range_q,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {IDLE, CLEAR, GATE, DEAD} state_t;

  localparam logic [CNT_W-1:0] LAST0     = CNT_W'(GATE_LEN0 - 1);
  localparam logic [CNT_W-1:0] LAST1     = CNT_W'(GATE_LEN1 - 1);
  localparam logic [CNT_W-1:0] LAST2     = CNT_W'(GATE_LEN2 - 1);
  localparam logic [CNT_W-1:0] LAST3     = CNT_W'(GATE_LEN3 - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_LEN - 1);

  state_t           state, state_nxt;
  logic             cont_q, cont_nxt;
  logic [1:0]       range_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             gate_done_nxt;

  function automatic logic [CNT_W-1:0] gate_last(input logic [1:0] r);
    case (r)
      2'd0:    gate_last = LAST0;
      2'd1:    gate_last = LAST1;
      2'd2:    gate_last = LAST2;
      default: gate_last = LAST3;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    range_nxt = range_q;
    cont_nxt  = cont_q;
    case (state)
      IDLE:    if (start && !stop) state_nxt = CLEAR;
      CLEAR:   state_nxt = GATE;
      GATE:    if (cnt == gate_last(range_q)) state_nxt = DEAD;
      DEAD:    if (cnt == DEAD_LAST) state_nxt = cont_q ? CLEAR : IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort wins over any normal transition once the sequence has started.
    if (stop && state != IDLE) state_nxt = IDLE;
    if (state_nxt == CLEAR) begin
      range_nxt = range_sel;
      cont_nxt  = cont;
    end
    cnt_nxt       = (state_nxt == state && state != IDLE) ? cnt + CNT_W'(1) : '0;
    gate_done_nxt = (state == GATE) && (state_nxt == DEAD);
  end

  // Outputs are decoded from the next state so every one of them leaves a flop.
  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      state     <= IDLE;
      cont_q    <= 1'b0;
      range_q   <= '0;
      cnt       <= '0;
      gateout   <= 1'b0;
      gate_clr  <= 1'b0;
      gate_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cont_q    <= cont_nxt;
      range_q   <= range_nxt;
      cnt       <= cnt_nxt;
      gateout   <= (state_nxt == GATE);
      gate_clr  <= (state_nxt == CLEAR);
      gate_done <= gate_done_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_gate_gen.sv
// Directed bench for gate_gen with short gate lengths; cycle 0 is the cycle in which
// start is held high, outputs are sampled 1 time unit after each rising edge.
module tb_gate_gen;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             Sys_RST = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             cont = 1'b0;
  logic [1:0]       range_sel = 2'd0;
  logic             gateout, gate_clr, gate_done, busy;
  logic [1:0]       range_q;
  logic [CNT_W-1:0] cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  gate_gen #(
    .CNT_W(CNT_W), .GATE_LEN0(8), .GATE_LEN1(4), .GATE_LEN2(2), .GATE_LEN3(1), .DEAD_LEN(3)
  ) dut (
    .Sys_CLK(clk), .Sys_RST(Sys_RST), .start(start), .stop(stop), .cont(cont),
    .range_sel(range_sel), .gateout(gateout), .gate_clr(gate_clr), .gate_done(gate_done),
    .busy(busy), .range_q(range_q), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_cyc(input string sc, input bit g, input bit c, input bit d, input bit b);
    chk($sformatf("%s gateout c%0d", sc, cyc), 32'(gateout), 32'(g));
    chk($sformatf("%s gate_clr c%0d", sc, cyc), 32'(gate_clr), 32'(c));
    chk($sformatf("%s gate_done c%0d", sc, cyc), 32'(gate_done), 32'(d));
    chk($sformatf("%s busy c%0d", sc, cyc), 32'(busy), 32'(b));
  endtask

  initial begin
    // Reset state
    Sys_RST = 1'b1;
    step();
    step();
    chk_cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset range_q", 32'(range_q), 32'd0);
    chk("reset cnt", 32'(cnt), 32'd0);
    Sys_RST = 1'b0;

    // Single-shot, range 0
    range_sel = 2'd0; cont = 1'b0; start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
    while (cyc <= 14) begin
      chk_cyc("single", cyc >= 2 && cyc <= 9, cyc == 1, cyc == 10, cyc >= 1 && cyc <= 12);
      chk($sformatf("single cnt c%0d", cyc), 32'(cnt),
          (cyc >= 2 && cyc <= 9) ? cyc - 2 : (cyc >= 10 && cyc <= 12) ? cyc - 10 : 0);
      chk($sformatf("single range_q c%0d", cyc), 32'(range_q), 32'd0);
      step();
    end

    // Continuous, range 1, cont dropped in cycle 12
    range_sel = 2'd1; cont = 1'b1; start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
    while (cyc <= 26) begin
      if (cyc == 12) cont = 1'b0;
      chk_cyc("cont",
              (cyc >= 2 && cyc <= 5) || (cyc >= 10 && cyc <= 13) || (cyc >= 18 && cyc <= 21),
              cyc == 1 || cyc == 9 || cyc == 17,
              cyc == 6 || cyc == 14 || cyc == 22,
              cyc >= 1 && cyc <= 24);
      step();
    end

    // Range change mid-gate, then stop on the last DEAD cycle
    range_sel = 2'd1; cont = 1'b1; start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
    while (cyc <= 16) begin
      if (cyc == 3) range_sel = 2'd2;
      if (cyc == 14) stop = 1'b1;
      if (cyc == 15) begin stop = 1'b0; cont = 1'b0; end
      chk_cyc("rchg", (cyc >= 2 && cyc <= 5) || (cyc >= 10 && cyc <= 11),
              cyc == 1 || cyc == 9, cyc == 6 || cyc == 12, cyc >= 1 && cyc <= 14);
      chk($sformatf("rchg range_q c%0d", cyc), 32'(range_q), (cyc <= 8) ? 32'd1 : 32'd2);
      step();
    end

    // Abort at cycle 5 of a range-0 gate
    range_sel = 2'd0; cont = 1'b0; start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
    while (cyc <= 9) begin
      if (cyc == 5) stop = 1'b1;
      if (cyc == 6) stop = 1'b0;
      chk_cyc("abort", cyc >= 2 && cyc <= 5, cyc == 1, 1'b0, cyc >= 1 && cyc <= 5);
      chk($sformatf("abort range_q c%0d", cyc), 32'(range_q), 32'd0);
      step();
    end

    // Range 3 after abort: one-cycle gate
    range_sel = 2'd3; start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
    while (cyc <= 7) begin
      chk_cyc("r3", cyc == 2, cyc == 1, cyc == 3, cyc >= 1 && cyc <= 5);
      chk($sformatf("r3 range_q c%0d", cyc), 32'(range_q), 32'd3);
      step();
    end

    // Reset mid-gate with start held high
    range_sel = 2'd1; start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
    while (cyc <= 8) begin
      if (cyc == 4) begin Sys_RST = 1'b1; start = 1'b1; end
      if (cyc == 5) Sys_RST = 1'b0;
      if (cyc == 6) start = 1'b0;
      chk_cyc("rst", (cyc >= 2 && cyc <= 4) || cyc >= 7, cyc == 1 || cyc == 6, 1'b0,
              cyc != 5);
      chk($sformatf("rst range_q c%0d", cyc), 32'(range_q), (cyc == 5) ? 32'd0 : 32'd1);
      chk($sformatf("rst cnt c%0d", cyc), 32'(cnt),
          (cyc >= 2 && cyc <= 4) ? cyc - 2 : (cyc >= 7) ? cyc - 7 : 0);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_cyc("rst_stop", 1'b0, 1'b0, 1'b0, 1'b0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1; cyc = 0;
    step();
    start = 1'b0; stop = 1'b0;
    while (cyc <= 3) begin
      chk_cyc("contend", 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
